pipeline_control: RTL and testbench
===================================

PIPELINE_CONTROL -- requirements
Module: pipeline_control

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of the saturating event counters.
REQ-002 SHALL have port clk  in  1: single clock, all state updates on its rising edge.
REQ-003 SHALL have port rst_n  in  1: reset, synchronous, active-low.
REQ-004 SHALL have port imemReady  in  1: instruction at the current PC is valid this cycle.
REQ-005 SHALL have port branchResult  in  1: taken branch resolved this cycle.
REQ-006 SHALL have port branchAddrs  in  32: branch target, valid with branchResult.
REQ-007 SHALL have port idExMemRead  in  1: instruction in ID/EX is a load.
REQ-008 SHALL have port idExRt  in  5: load destination register.
REQ-009 SHALL have ports ifIdRs and ifIdRt  in  5 each: source registers of the IF/ID instruction.
REQ-010 SHALL have port ifIdUsesRt  in  1: the IF/ID instruction reads rt.
REQ-011 SHALL have port pcSel  out  2: PC mux select; 00 = PC+4, 01 = branch target, 10 = hold PC.
REQ-012 SHALL have port pcTarget  out  32: branch target presented to the PC mux.
REQ-013 SHALL have ports ifFlush, regStall and bubbleIdEx  out  1 each: zero the IF/ID register, hold the IF/ID register, and insert a NOP into ID/EX.
REQ-014 SHALL have ports stallCount and flushCount  out  CNT_W each, plus ctrlState  out  2 for debug.

Function
REQ-015 SHALL implement an FSM with states RUN, WAIT and PEND.
REQ-016 SHALL drive all control outputs combinationally from the current state and inputs (zero latency); state, target register and counters SHALL update at the next edge.
REQ-017 SHALL detect loadUse = idExMemRead && idExRt!=0 && (idExRt==ifIdRs || (ifIdUsesRt && idExRt==ifIdRt)).
REQ-018 RUN, imemReady=1, no branch, no loadUse: SHALL drive pcSel=00 and all flags 0; next state RUN.
REQ-019 RUN, imemReady=1, loadUse, no branch: SHALL drive pcSel=10, regStall=1, bubbleIdEx=1, ifFlush=0 for that single cycle; next state RUN.
REQ-020 RUN, imemReady=1, branchResult=1: SHALL drive pcSel=01, pcTarget=branchAddrs, ifFlush=1, regStall=0 and bubbleIdEx=0; branchResult SHALL override loadUse; next state RUN.
REQ-021 RUN, imemReady=0, no branch: SHALL drive pcSel=10 and ifFlush=1; next state WAIT.
REQ-022 WAIT SHALL drive pcSel=10 and ifFlush=1 while imemReady=0; if loadUse is also true, it SHALL instead drive regStall=1, bubbleIdEx=1 and ifFlush=0.
REQ-023 WAIT with imemReady=1 SHALL behave exactly as RUN in that cycle (REQ-018..020); next state RUN, or PEND per REQ-024.
REQ-024 branchResult=1 with imemReady=0 (RUN or WAIT) SHALL latch branchAddrs into the target register, drive pcSel=10 and ifFlush=1; next state PEND.
REQ-025 PEND with imemReady=0 SHALL drive pcSel=10 and ifFlush=1, and SHALL ignore branchResult.
REQ-026 PEND with imemReady=1 SHALL drive pcSel=01, pcTarget=latched target and ifFlush=1 (discarding the stale instruction); next state RUN.
REQ-027 Outside REQ-020/026, pcTarget SHALL equal the latched target register.
REQ-028 stallCount SHALL increment on every cycle with pcSel=10 and rst_n=1, saturating at all ones.
REQ-029 flushCount SHALL increment on every cycle with ifFlush=1 and rst_n=1, saturating at all ones.

Reset
REQ-030 While rst_n=0 at an edge, the block SHALL set state=RUN, target register=0, and both counters=0.
REQ-031 While rst_n=0, outputs SHALL be pcSel=10, ifFlush=1, regStall=0, bubbleIdEx=0, regardless of other inputs.
REQ-032 Reset asserted while in WAIT or PEND SHALL discard any pending branch; the first cycle after release SHALL be RUN.

Structure
REQ-033 The shared package SHALL hold the state encodings (RUN=0, WAIT=1, PEND=2) and the pcSel codes (PC4=00, BR=01, HOLD=10).
REQ-034 The loadUse comparator SHALL be a separate combinational sub-module named hazard_detect.

Verification
REQ-035 idExMemRead=1, idExRt=5, ifIdRs=5, imemReady=1 for one cycle -> one cycle of pcSel=10, regStall=1, bubbleIdEx=1; stallCount=1.
REQ-036 Same as REQ-035 with idExRt=0 -> no stall; pcSel=00.
REQ-037 branchResult=1, branchAddrs=0x40, loadUse=1, imemReady=1 -> pcSel=01, pcTarget=0x40, ifFlush=1, bubbleIdEx=0.
REQ-038 imemReady=0 for 3 cycles with branchResult=1 (branchAddrs=0x80) in the first, then imemReady=1 -> 3 cycles of pcSel=10 and ifFlush=1, then pcSel=01 with pcTarget=0x80; state returns to RUN; flushCount=4.
REQ-039 rst_n=0 during PEND -> pcSel=10, ifFlush=1; after release, state=RUN, counters=0, pcTarget=0.
REQ-040 With CNT_W=4, drive 20 hold cycles -> stallCount saturates at 15.

Source files
------------

// File: rtl/pipeline_control_pkg.sv
// pipeline_control_pkg: shared state encodings and PC mux select codes for the pipeline controller.
package pipeline_control_pkg;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        WAIT = 2'd1,
        PEND = 2'd2
    } ctrlState_e;

    localparam logic [1:0] PC4  = 2'b00;
    localparam logic [1:0] BR   = 2'b01;
    localparam logic [1:0] HOLD = 2'b10;

endpackage

// File: rtl/pipeline_control_hazard_detect.sv
// hazard_detect: flags a load in ID/EX whose destination is read by the instruction in IF/ID.
module hazard_detect (
    input  logic       idExMemRead,
    input  logic [4:0] idExRt,
    input  logic [4:0] ifIdRs,
    input  logic [4:0] ifIdRt,
    input  logic       ifIdUsesRt,
    output logic       loadUse
);

    assign loadUse = idExMemRead && idExRt != 5'd0 &&
                     (idExRt == ifIdRs || (ifIdUsesRt && idExRt == ifIdRt));

endmodule

// File: rtl/pipeline_control.sv
// pipeline_control: PC select, flush/stall/bubble generation with branch deferral across instruction-memory waits.
module pipeline_control
    import pipeline_control_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             imemReady,
    input  logic             branchResult,
    input  logic [31:0]      branchAddrs,
    input  logic             idExMemRead,
    input  logic [4:0]       idExRt,
    input  logic [4:0]       ifIdRs,
    input  logic [4:0]       ifIdRt,
    input  logic             ifIdUsesRt,
    output logic [1:0]       pcSel,
    output logic [31:0]      pcTarget,
    output logic             ifFlush,
    output logic             regStall,
    output logic             bubbleIdEx,
    output logic [CNT_W-1:0] stallCount,
    output logic [CNT_W-1:0] flushCount,
    output logic [1:0]       ctrlState
);

    ctrlState_e  state, nextState;
    logic [31:0] targetReg, nextTarget;
    logic        loadUse;

    hazard_detect uHazard (
        .idExMemRead(idExMemRead),
        .idExRt     (idExRt),
        .ifIdRs     (ifIdRs),
        .ifIdRt     (ifIdRt),
        .ifIdUsesRt (ifIdUsesRt),
        .loadUse    (loadUse)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= RUN;
            targetReg  <= '0;
            stallCount <= '0;
            flushCount <= '0;
        end else begin
            state     <= nextState;
            targetReg <= nextTarget;
            if (pcSel == HOLD && stallCount != '1) stallCount <= stallCount + 1'b1;
            if (ifFlush && flushCount != '1) flushCount <= flushCount + 1'b1;
        end
    end

    // Default is the safe hold-and-flush response used by reset, waits and pending branches.
    always_comb begin
        nextState  = state;
        nextTarget = targetReg;
        pcSel      = HOLD;
        pcTarget   = targetReg;
        ifFlush    = 1'b1;
        regStall   = 1'b0;
        bubbleIdEx = 1'b0;
        if (!rst_n) begin
            nextState = RUN;
        end else if (state == PEND) begin
            if (imemReady) begin
                pcSel     = BR;
                nextState = RUN;
            end
        end else if (imemReady) begin
            nextState = RUN;
            if (branchResult) begin
                pcSel    = BR;
                pcTarget = branchAddrs;
            end else begin
                pcSel      = loadUse ? HOLD : PC4;
                ifFlush    = 1'b0;
                regStall   = loadUse;
                bubbleIdEx = loadUse;
            end
        end else if (branchResult) begin
            nextTarget = branchAddrs;
            nextState  = PEND;
        end else begin
            nextState = WAIT;
            if (state == WAIT && loadUse) begin
                ifFlush    = 1'b0;
                regStall   = 1'b1;
                bubbleIdEx = 1'b1;
            end
        end
    end

    assign ctrlState = state;

endmodule

// File: tb/tb_pipeline_control.sv
// tb_pipeline_control: directed and randomized checks against a cycle-level reference model.
module tb_pipeline_control;

    logic        clk = 1'b0;
    logic        rst_n, imemReady, branchResult, idExMemRead, ifIdUsesRt;
    logic [31:0] branchAddrs;
    logic [4:0]  idExRt, ifIdRs, ifIdRt;
    logic [1:0]  pcSel, pcSelS, ctrlState, ctrlStateS;
    logic [31:0] pcTarget, pcTargetS;
    logic        ifFlush, regStall, bubbleIdEx, ifFlushS, regStallS, bubbleIdExS;
    logic [15:0] stallCount, flushCount;
    logic [3:0]  stallCountS, flushCountS;

    int vec = 0;
    int errs = 0;

    logic        mPend, mWait;
    logic [31:0] mTarget;
    int          mStall, mFlush;
    logic [1:0]  eSel;
    logic [31:0] eTgt;
    logic        eFlush, eStall, eBub;

    always #5 clk = ~clk;

    pipeline_control dut (
        .clk(clk), .rst_n(rst_n), .imemReady(imemReady), .branchResult(branchResult),
        .branchAddrs(branchAddrs), .idExMemRead(idExMemRead), .idExRt(idExRt),
        .ifIdRs(ifIdRs), .ifIdRt(ifIdRt), .ifIdUsesRt(ifIdUsesRt),
        .pcSel(pcSel), .pcTarget(pcTarget), .ifFlush(ifFlush), .regStall(regStall),
        .bubbleIdEx(bubbleIdEx), .stallCount(stallCount), .flushCount(flushCount),
        .ctrlState(ctrlState)
    );

    pipeline_control #(.CNT_W(4)) dutS (
        .clk(clk), .rst_n(rst_n), .imemReady(imemReady), .branchResult(branchResult),
        .branchAddrs(branchAddrs), .idExMemRead(idExMemRead), .idExRt(idExRt),
        .ifIdRs(ifIdRs), .ifIdRt(ifIdRt), .ifIdUsesRt(ifIdUsesRt),
        .pcSel(pcSelS), .pcTarget(pcTargetS), .ifFlush(ifFlushS), .regStall(regStallS),
        .bubbleIdEx(bubbleIdExS), .stallCount(stallCountS), .flushCount(flushCountS),
        .ctrlState(ctrlStateS)
    );

    // Reference: a pending branch waits for the next ready instruction; a wait only
    // lets a load-use stall through once the fetch miss has already been flushed once.
    task automatic calcExpected();
        logic lu;
        lu = idExMemRead && idExRt != 0 && (idExRt == ifIdRs || (ifIdUsesRt && idExRt == ifIdRt));
        eSel = 2'b10; eTgt = mTarget; eFlush = 1; eStall = 0; eBub = 0;
        if (!rst_n) begin
        end else if (mPend) begin
            if (imemReady) eSel = 2'b01;
        end else if (imemReady) begin
            if (branchResult) begin
                eSel = 2'b01; eTgt = branchAddrs;
            end else if (lu) begin
                eStall = 1; eBub = 1; eFlush = 0;
            end else begin
                eSel = 2'b00; eFlush = 0;
            end
        end else if (!branchResult && mWait && lu) begin
            eStall = 1; eBub = 1; eFlush = 0;
        end
    endtask

    task automatic tick();
        calcExpected();
        @(posedge clk);
        if (!rst_n) begin
            mPend = 0; mWait = 0; mTarget = 0; mStall = 0; mFlush = 0;
        end else begin
            if (eSel == 2'b10) mStall++;
            if (eFlush) mFlush++;
            if (mPend) begin
                if (imemReady) mPend = 0;
            end else if (imemReady) begin
                mWait = 0;
            end else if (branchResult) begin
                mPend = 1; mTarget = branchAddrs; mWait = 0;
            end else begin
                mWait = 1;
            end
        end
        #1;
    endtask

    task automatic idle();
        rst_n = 1; imemReady = 1; branchResult = 0; branchAddrs = 0;
        idExMemRead = 0; idExRt = 0; ifIdRs = 0; ifIdRt = 0; ifIdUsesRt = 0;
    endtask

    task automatic doReset();
        idle();
        rst_n = 0;
        tick();
        tick();
        rst_n = 1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin
            rst_n = 0; imemReady = 1'($urandom); branchResult = 1'($urandom);
            branchAddrs = $urandom; idExMemRead = 1; idExRt = 3; ifIdRs = 3;
            #4;
            vec++;
            if (pcSel !== 2'b10 || ifFlush !== 1 || regStall !== 0 || bubbleIdEx !== 0) begin
                errs++;
                $display("FAIL reset_outputs: pcSel=%b ifFlush=%b regStall=%b bubble=%b required 10/1/0/0",
                         pcSel, ifFlush, regStall, bubbleIdEx);
            end
            tick();
        end
        idle();
        #4;
        vec++;
        if (ctrlState !== 2'd0 || stallCount !== 0 || flushCount !== 0 || pcTarget !== 0) begin
            errs++;
            $display("FAIL reset_state: state=%0d stall=%0d flush=%0d tgt=%h required 0/0/0/0",
                     ctrlState, stallCount, flushCount, pcTarget);
        end
        tick();
    endtask

    task automatic test_load_use();
        doReset();
        idExMemRead = 1; idExRt = 5; ifIdRs = 5; ifIdRt = 9;
        #4;
        vec++;
        if (pcSel !== 2'b10 || regStall !== 1 || bubbleIdEx !== 1 || ifFlush !== 0) begin
            errs++;
            $display("FAIL load_use: pcSel=%b stall=%b bubble=%b flush=%b required 10/1/1/0",
                     pcSel, regStall, bubbleIdEx, ifFlush);
        end
        tick();
        idle();
        #4;
        vec++;
        if (stallCount !== 1 || pcSel !== 2'b00 || regStall !== 0) begin
            errs++;
            $display("FAIL load_use_after: stallCount=%0d pcSel=%b stall=%b required 1/00/0",
                     stallCount, pcSel, regStall);
        end
        tick();
        idExMemRead = 1; idExRt = 7; ifIdRs = 1; ifIdRt = 7; ifIdUsesRt = 1;
        #4;
        vec++;
        if (regStall !== 1) begin
            errs++;
            $display("FAIL load_use_rt: regStall=%b required 1", regStall);
        end
        ifIdUsesRt = 0;
        #1;
        vec++;
        if (regStall !== 0 || pcSel !== 2'b00) begin
            errs++;
            $display("FAIL load_use_rt_unused: regStall=%b pcSel=%b required 0/00", regStall, pcSel);
        end
        tick();
    endtask

    task automatic test_rt_zero();
        doReset();
        idExMemRead = 1; idExRt = 0; ifIdRs = 0;
        #4;
        vec++;
        if (pcSel !== 2'b00 || regStall !== 0 || bubbleIdEx !== 0) begin
            errs++;
            $display("FAIL rt_zero: pcSel=%b stall=%b bubble=%b required 00/0/0", pcSel, regStall, bubbleIdEx);
        end
        tick();
    endtask

    task automatic test_branch_override();
        doReset();
        branchResult = 1; branchAddrs = 32'h40; idExMemRead = 1; idExRt = 4; ifIdRs = 4;
        #4;
        vec++;
        if (pcSel !== 2'b01 || pcTarget !== 32'h40 || ifFlush !== 1 || bubbleIdEx !== 0 || regStall !== 0) begin
            errs++;
            $display("FAIL branch_override: pcSel=%b tgt=%h flush=%b bubble=%b stall=%b required 01/40/1/0/0",
                     pcSel, pcTarget, ifFlush, bubbleIdEx, regStall);
        end
        tick();
    endtask

    task automatic test_wait_load_use();
        doReset();
        imemReady = 0; idExMemRead = 1; idExRt = 6; ifIdRs = 6;
        #4;
        vec++;
        if (pcSel !== 2'b10 || ifFlush !== 1 || regStall !== 0) begin
            errs++;
            $display("FAIL run_miss: pcSel=%b flush=%b stall=%b required 10/1/0", pcSel, ifFlush, regStall);
        end
        tick();
        #4;
        vec++;
        if (ctrlState !== 2'd1 || ifFlush !== 0 || regStall !== 1 || bubbleIdEx !== 1 || pcSel !== 2'b10) begin
            errs++;
            $display("FAIL wait_load_use: state=%0d flush=%b stall=%b bubble=%b pcSel=%b required 1/0/1/1/10",
                     ctrlState, ifFlush, regStall, bubbleIdEx, pcSel);
        end
        tick();
    endtask

    task automatic test_pend_branch();
        doReset();
        for (int i = 0; i < 3; i++) begin
            imemReady = 0;
            branchResult = (i != 1);
            branchAddrs = (i == 0) ? 32'h80 : 32'hDEAD_0000;
            #4;
            vec++;
            if (pcSel !== 2'b10 || ifFlush !== 1) begin
                errs++;
                $display("FAIL pend_hold[%0d]: pcSel=%b flush=%b required 10/1", i, pcSel, ifFlush);
            end
            tick();
        end
        imemReady = 1; branchResult = 0; branchAddrs = 0;
        #4;
        vec++;
        if (pcSel !== 2'b01 || pcTarget !== 32'h80 || ifFlush !== 1) begin
            errs++;
            $display("FAIL pend_release: pcSel=%b tgt=%h flush=%b required 01/80/1", pcSel, pcTarget, ifFlush);
        end
        tick();
        idle();
        #4;
        vec++;
        if (ctrlState !== 2'd0 || flushCount !== 4 || stallCount !== 3) begin
            errs++;
            $display("FAIL pend_after: state=%0d flush=%0d stall=%0d required 0/4/3", ctrlState, flushCount, stallCount);
        end
        tick();
    endtask

    task automatic test_reset_in_pend();
        doReset();
        imemReady = 0; branchResult = 1; branchAddrs = 32'h1234;
        tick();
        branchResult = 0;
        tick();
        rst_n = 0; imemReady = 1;
        #4;
        vec++;
        if (pcSel !== 2'b10 || ifFlush !== 1) begin
            errs++;
            $display("FAIL reset_in_pend: pcSel=%b flush=%b required 10/1", pcSel, ifFlush);
        end
        tick();
        idle();
        #4;
        vec++;
        if (ctrlState !== 2'd0 || stallCount !== 0 || flushCount !== 0 || pcTarget !== 0 || pcSel !== 2'b00) begin
            errs++;
            $display("FAIL reset_in_pend_after: state=%0d stall=%0d flush=%0d tgt=%h pcSel=%b required 0/0/0/0/00",
                     ctrlState, stallCount, flushCount, pcTarget, pcSel);
        end
        tick();
    endtask

    task automatic test_saturation();
        doReset();
        imemReady = 0;
        for (int i = 0; i < 20; i++) tick();
        #4;
        vec++;
        if (stallCountS !== 4'd15 || flushCountS !== 4'd15 || stallCount !== 16'd20) begin
            errs++;
            $display("FAIL saturation: small stall=%0d flush=%0d wide stall=%0d required 15/15/20",
                     stallCountS, flushCountS, stallCount);
        end
        tick();
    endtask

    task automatic test_random();
        doReset();
        for (int c = 0; c < 400; c++) begin
            rst_n        = ($urandom_range(31) != 0);
            imemReady    = ($urandom_range(3) != 0);
            branchResult = ($urandom_range(4) == 0);
            branchAddrs  = $urandom;
            idExMemRead  = 1'($urandom);
            idExRt       = 5'($urandom_range(3));
            ifIdRs       = 5'($urandom_range(3));
            ifIdRt       = 5'($urandom_range(3));
            ifIdUsesRt   = 1'($urandom);
            #4;
            calcExpected();
            vec++;
            if (pcSel !== eSel || pcTarget !== eTgt || ifFlush !== eFlush || regStall !== eStall || bubbleIdEx !== eBub) begin
                errs++;
                $display("FAIL rand_out[%0d]: sel=%b tgt=%h fl=%b st=%b bu=%b required %b/%h/%b/%b/%b",
                         c, pcSel, pcTarget, ifFlush, regStall, bubbleIdEx, eSel, eTgt, eFlush, eStall, eBub);
            end
            vec++;
            if (ctrlState !== (mPend ? 2'd2 : mWait ? 2'd1 : 2'd0) || stallCount !== 16'(mStall) ||
                flushCount !== 16'(mFlush) || stallCountS !== 4'(mStall > 15 ? 15 : mStall) ||
                flushCountS !== 4'(mFlush > 15 ? 15 : mFlush)) begin
                errs++;
                $display("FAIL rand_state[%0d]: state=%0d stall=%0d flush=%0d sS=%0d fS=%0d required pend=%0d wait=%0d stall=%0d flush=%0d",
                         c, ctrlState, stallCount, flushCount, stallCountS, flushCountS, mPend, mWait, mStall, mFlush);
            end
            tick();
        end
    endtask

    initial begin
        mPend = 0; mWait = 0; mTarget = 0; mStall = 0; mFlush = 0;
        idle();
        rst_n = 0;
        @(posedge clk);
        #1;
        test_reset();
        test_load_use();
        test_rt_zero();
        test_branch_override();
        test_wait_load_use();
        test_pend_branch();
        test_reset_in_pend();
        test_saturation();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
